// File: rtl/frame_config_pkg.sv
// Shared types and constants for the frame configuration sequencer.
package frame_config_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCommit,
        StDone
    } seq_state_e;

    // Header word field positions
    localparam int unsigned COL_MSB = 31;
    localparam int unsigned COL_LSB = 27;
    localparam int unsigned FRM_MSB = 26;
    localparam int unsigned FRM_LSB = 22;

    localparam int unsigned DEF_FRAME_BITS_PER_ROW = 32;
    localparam int unsigned DEF_ROW_SELECT_WIDTH   = 5;
    localparam int unsigned DEF_NUMBER_OF_ROWS     = 12;
    localparam int unsigned DEF_NUMBER_OF_COLS     = 8;
    localparam int unsigned DEF_MAX_FRAMES_PER_COL = 20;
    localparam int unsigned DEF_COL_SELECT_WIDTH   = 5;
    localparam int unsigned DEF_FRAME_SELECT_WIDTH = 5;

endpackage

// File: rtl/frame_seq_checksum.sv
// XOR accumulator over a frame's row words; o_match compares the running XOR with i_data.
module frame_seq_checksum
    import frame_config_pkg::*;
#(
    parameter int unsigned Width = DEF_FRAME_BITS_PER_ROW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_accum,
    input  logic [Width-1:0] i_data,
    output logic             o_match
);

    logic [Width-1:0] r_acc_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc_q <= '0;
        end else if (i_clear) begin
            r_acc_q <= '0;
        end else if (i_accum) begin
            r_acc_q <= r_acc_q ^ i_data;
        end
    end

    assign o_match = (r_acc_q == i_data);

endmodule

// File: rtl/frame_config_sequencer.sv
// Loads a header plus NumberOfRows row words, broadcasts each row, then pulses FrameStrobe.
// Build option FRAME_SEQ_CHECKSUM_EN: a trailing XOR checksum word must match before commit.
module frame_config_sequencer
    import frame_config_pkg::*;
#(
    parameter int unsigned FrameBitsPerRow  = DEF_FRAME_BITS_PER_ROW,
    parameter int unsigned RowSelectWidth   = DEF_ROW_SELECT_WIDTH,
    parameter int unsigned NumberOfRows     = DEF_NUMBER_OF_ROWS,
    parameter int unsigned NumberOfCols     = DEF_NUMBER_OF_COLS,
    parameter int unsigned MaxFramesPerCol  = DEF_MAX_FRAMES_PER_COL,
    parameter int unsigned ColSelectWidth   = DEF_COL_SELECT_WIDTH,
    parameter int unsigned FrameSelectWidth = DEF_FRAME_SELECT_WIDTH
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic [FrameBitsPerRow-1:0]  WriteData,
    input  logic                        WriteValid,
    output logic                        WriteReady,
    input  logic                        Abort,
    input  logic                        ErrClear,
    output logic [FrameBitsPerRow-1:0]  FrameData_O,
    output logic [RowSelectWidth-1:0]   RowSelect,
    output logic [ColSelectWidth-1:0]   ColSelect,
    output logic [FrameSelectWidth-1:0] FrameSelect,
    output logic                        FrameStrobe,
    output logic                        Busy,
    output logic                        Error
);

    localparam int unsigned HdrColW = COL_MSB - COL_LSB + 1;
    localparam int unsigned HdrFrmW = FRM_MSB - FRM_LSB + 1;
    localparam logic [HdrColW-1:0] LpNumCols   = HdrColW'(NumberOfCols);
    localparam logic [HdrFrmW-1:0] LpMaxFrames = HdrFrmW'(MaxFramesPerCol);
    localparam logic [RowSelectWidth-1:0] LpLastRow = RowSelectWidth'(NumberOfRows);

    seq_state_e                  r_state_q, w_state_d;
    logic [RowSelectWidth-1:0]   r_cnt_q, w_cnt_d;
    logic [RowSelectWidth-1:0]   r_row_sel_q, w_row_sel_d;
    logic [FrameBitsPerRow-1:0]  r_data_q, w_data_d;
    logic [ColSelectWidth-1:0]   r_col_q, w_col_d;
    logic [FrameSelectWidth-1:0] r_frm_q, w_frm_d;
    logic                        r_strobe_q, w_strobe_d;
    logic                        r_busy_q, w_busy_d;
    logic                        r_error_q, w_error_d;

    logic               w_xfer;
    logic               w_hdr_bad;
    logic [HdrColW-1:0] w_hdr_col;
    logic [HdrFrmW-1:0] w_hdr_frm;

    assign WriteReady = resetn & ((r_state_q == StIdle) | (r_state_q == StLoad));
    assign w_xfer     = WriteValid & WriteReady;
    assign w_hdr_col  = WriteData[COL_MSB:COL_LSB];
    assign w_hdr_frm  = WriteData[FRM_MSB:FRM_LSB];
    assign w_hdr_bad  = (w_hdr_col >= LpNumCols) | (w_hdr_frm >= LpMaxFrames);

`ifdef FRAME_SEQ_CHECKSUM_EN
    // Set once the last row is in; the next LOAD transfer is the checksum word.
    logic r_chk_phase_q, w_chk_phase_d;
    logic w_chk_clear, w_chk_accum, w_chk_match;

    frame_seq_checksum #(
        .Width (FrameBitsPerRow)
    ) u_checksum (
        .i_clk   (CLK),
        .i_rst_n (resetn),
        .i_clear (w_chk_clear),
        .i_accum (w_chk_accum),
        .i_data  (WriteData),
        .o_match (w_chk_match)
    );
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_row_sel_d = '0;
        w_data_d    = r_data_q;
        w_col_d     = r_col_q;
        w_frm_d     = r_frm_q;
        w_strobe_d  = 1'b0;
        w_busy_d    = r_busy_q;
        w_error_d   = r_error_q & ~ErrClear;
`ifdef FRAME_SEQ_CHECKSUM_EN
        w_chk_phase_d = r_chk_phase_q;
        w_chk_clear   = 1'b0;
        w_chk_accum   = 1'b0;
`endif
        case (r_state_q)
            StIdle: begin
                if (w_xfer) begin
                    if (w_hdr_bad) begin
                        w_error_d = 1'b1;
                    end else begin
                        w_col_d   = ColSelectWidth'(w_hdr_col);
                        w_frm_d   = FrameSelectWidth'(w_hdr_frm);
                        w_cnt_d   = RowSelectWidth'(1);
                        w_busy_d  = 1'b1;
                        w_state_d = StLoad;
`ifdef FRAME_SEQ_CHECKSUM_EN
                        w_chk_clear   = 1'b1;
                        w_chk_phase_d = 1'b0;
`endif
                    end
                end
            end
            StLoad: begin
                if (Abort) begin
                    w_busy_d  = 1'b0;
                    w_state_d = StIdle;
                end else if (w_xfer) begin
`ifdef FRAME_SEQ_CHECKSUM_EN
                    if (r_chk_phase_q) begin
                        if (w_chk_match) begin
                            w_state_d = StCommit;
                        end else begin
                            w_error_d = 1'b1;
                            w_state_d = StDone;
                        end
                    end else begin
                        w_chk_accum = 1'b1;
                        w_data_d    = WriteData;
                        w_row_sel_d = r_cnt_q;
                        if (r_cnt_q == LpLastRow) begin
                            w_chk_phase_d = 1'b1;
                        end else begin
                            w_cnt_d = r_cnt_q + RowSelectWidth'(1);
                        end
                    end
`else
                    w_data_d    = WriteData;
                    w_row_sel_d = r_cnt_q;
                    if (r_cnt_q == LpLastRow) begin
                        w_state_d = StCommit;
                    end else begin
                        w_cnt_d = r_cnt_q + RowSelectWidth'(1);
                    end
`endif
                end
            end
            StCommit: begin
                if (Abort) begin
                    w_busy_d  = 1'b0;
                    w_state_d = StIdle;
                end else begin
                    w_strobe_d = 1'b1;
                    w_state_d  = StDone;
                end
            end
            StDone: begin
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state_q   <= StIdle;
            r_cnt_q     <= '0;
            r_row_sel_q <= '0;
            r_data_q    <= '0;
            r_col_q     <= '0;
            r_frm_q     <= '0;
            r_strobe_q  <= 1'b0;
            r_busy_q    <= 1'b0;
            r_error_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_row_sel_q <= w_row_sel_d;
            r_data_q    <= w_data_d;
            r_col_q     <= w_col_d;
            r_frm_q     <= w_frm_d;
            r_strobe_q  <= w_strobe_d;
            r_busy_q    <= w_busy_d;
            r_error_q   <= w_error_d;
        end
    end

`ifdef FRAME_SEQ_CHECKSUM_EN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_chk_phase_q <= 1'b0;
        end else begin
            r_chk_phase_q <= w_chk_phase_d;
        end
    end
`endif

    assign FrameData_O = r_data_q;
    assign RowSelect   = r_row_sel_q;
    assign ColSelect   = r_col_q;
    assign FrameSelect = r_frm_q;
    assign FrameStrobe = r_strobe_q;
    assign Busy        = r_busy_q;
    assign Error       = r_error_q;

endmodule
